// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite mask renderer.
// Holds the per-channel config record, the pipeline depth and the ROM address-width helper.
package sprite_pkg;

    localparam int SPRITE_LATENCY = 4;
    localparam int SHAPE_BITS     = 4;

    typedef struct packed {
        logic [10:0]           x;
        logic [9:0]            y;
        logic [SHAPE_BITS-1:0] shape;
        logic                  en;
        logic                  flip;
    } sprite_cfg_t;

    function automatic int sprite_addr_width(input int w, input int h, input int n);
        return $clog2(w * h * n);
    endfunction

endpackage

// File: rtl/sprite_channel.sv
// One sprite channel: shadow/active config, S1 range and address, two-cycle ROM read.
// Contribution appears 3 cycles after the count is sampled; config writes are always accepted.
module sprite_channel
    import sprite_pkg::*;
#(
    parameter int    WIDTH     = 128,
    parameter int    HEIGHT    = 128,
    parameter int    NUM_IMGS  = 4,
    parameter int    SHP_W     = 2,
    parameter string INIT_FILE = "all_shape_small_img_mask.mem"
) (
    input  logic             pixel_clk_in,
    input  logic             rst_n_in,
    input  logic [10:0]      hcount_in,
    input  logic [9:0]       vcount_in,
    input  logic             new_frame_in,
    input  logic             cfg_we_in,
    input  logic [10:0]      cfg_x_in,
    input  logic [9:0]       cfg_y_in,
    input  logic [SHP_W-1:0] cfg_shape_in,
    input  logic             cfg_en_in,
    input  logic             cfg_flip_in,
    output logic             contrib_out
);

    localparam int AW = sprite_addr_width(WIDTH, HEIGHT, NUM_IMGS);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);

    sprite_cfg_t shadow;
    sprite_cfg_t active;
    sprite_cfg_t cfg_new;

    assign cfg_new = '{x: cfg_x_in, y: cfg_y_in, shape: SHAPE_BITS'(cfg_shape_in),
                       en: cfg_en_in, flip: cfg_flip_in};

    // Commit reads the old shadow, so a same-cycle write waits for the next frame.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (cfg_we_in)    shadow <= cfg_new;
            if (new_frame_in) active <= shadow;
        end
    end

    logic [11:0]   x_end;
    logic [10:0]   y_end;
    logic [CW-1:0] dx;
    logic [RW-1:0] dy;
    logic [CW-1:0] col;
    logic          hit;
    logic [AW-1:0] addr_c;

    assign x_end = {1'b0, active.x} + 12'(WIDTH);
    assign y_end = {1'b0, active.y} + 11'(HEIGHT);
    assign dx    = CW'(hcount_in - active.x);
    assign dy    = RW'(vcount_in - active.y);
    assign col   = active.flip ? ~dx : dx;

    // Wide end-of-sprite sums clip at the screen edge instead of wrapping to column 0.
    assign hit = active.en && (32'(active.shape) < NUM_IMGS)
              && (hcount_in >= active.x) && ({1'b0, hcount_in} < x_end)
              && (vcount_in >= active.y) && ({1'b0, vcount_in} < y_end);

    assign addr_c = AW'(active.shape) * AW'(WIDTH * HEIGHT) + AW'(dy) * AW'(WIDTH) + AW'(col);

    logic [AW-1:0] addr_s1;
    logic          flag_s1;
    logic          flag_s2;
    logic          flag_s3;

    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            addr_s1 <= '0;
            flag_s1 <= 1'b0;
            flag_s2 <= 1'b0;
            flag_s3 <= 1'b0;
        end else begin
            addr_s1 <= hit ? addr_c : '0;
            flag_s1 <= hit;
            flag_s2 <= flag_s1;
            flag_s3 <= flag_s2;
        end
    end

    logic rom_q;

    xilinx_single_port_ram_read_first #(
        .RAM_DEPTH       (WIDTH * HEIGHT * NUM_IMGS),
        .RAM_PERFORMANCE ("HIGH_PERFORMANCE"),
        .INIT_FILE       (INIT_FILE),
        .IMG_W           (WIDTH),
        .IMG_H           (HEIGHT)
    ) u_rom (
        .clka   (pixel_clk_in),
        .addra  (addr_s1),
        .ena    (1'b1),
        .rsta   (~rst_n_in),
        .regcea (1'b1),
        .douta  (rom_q)
    );

    assign contrib_out = flag_s3 & rom_q;

endmodule

// File: rtl/xilinx_single_port_ram_read_first.sv
// 1-bit mask image ROM in the single-port read-first template; read latency 1 (LOW_LATENCY) or 2 (HIGH_PERFORMANCE).
// Always accepts an address; rsta synchronously clears the output register.
module xilinx_single_port_ram_read_first #(
    parameter int    RAM_DEPTH       = 65536,
    parameter string RAM_PERFORMANCE = "HIGH_PERFORMANCE",
    parameter string INIT_FILE       = "",
    parameter int    IMG_W           = 128,
    parameter int    IMG_H           = 128
) (
    input  logic                         clka,
    input  logic [$clog2(RAM_DEPTH)-1:0] addra,
    input  logic                         ena,
    input  logic                         rsta,
    input  logic                         regcea,
    output logic                         douta
);

    localparam int  AW       = $clog2(RAM_DEPTH);
    localparam int  CW       = $clog2(IMG_W);
    localparam int  RW       = $clog2(IMG_H);
    localparam bit  BLANK    = (INIT_FILE == "");
    localparam bit  OUT_REG  = (RAM_PERFORMANCE == "HIGH_PERFORMANCE");

    // Shape generator standing in for the mask image: solid, checker, left half, top half.
    function automatic logic image_bit(input logic [AW-1:0] a);
        int            shape;
        int            pix;
        logic [CW-1:0] col;
        logic [RW-1:0] row;
        logic          b;
        shape = int'(a) / (IMG_W * IMG_H);
        pix   = int'(a) % (IMG_W * IMG_H);
        col   = CW'(pix % IMG_W);
        row   = RW'(pix / IMG_W);
        case (shape % 4)
            0:       b = 1'b1;
            1:       b = ~(row[0] ^ col[0]);
            2:       b = ~col[CW-1];
            default: b = ~row[RW-1];
        endcase
        return BLANK ? 1'b0 : b;
    endfunction

    logic ram_data;
    logic douta_reg;

    always_ff @(posedge clka) begin
        if (ena) ram_data <= image_bit(addra);
    end

    always_ff @(posedge clka) begin
        if (rsta)        douta_reg <= 1'b0;
        else if (regcea) douta_reg <= ram_data;
    end

    assign douta = OUT_REG ? douta_reg : ram_data;

endmodule

// File: rtl/sprite_layer_mask.sv
// Multi-sprite mask renderer: per-channel lookups, fixed lowest-index priority, per-frame collision report.
// 4-cycle latency from counts to draw/id/collision; no backpressure, one pixel per clock.
module sprite_layer_mask
    import sprite_pkg::*;
#(
    parameter int    WIDTH       = 128,
    parameter int    HEIGHT      = 128,
    parameter int    NUM_IMGS    = 4,
    parameter int    NUM_SPRITES = 4,
    parameter string INIT_FILE   = "all_shape_small_img_mask.mem"
) (
    input  logic                                                   pixel_clk_in,
    input  logic                                                   rst_n_in,
    input  logic [10:0]                                            hcount_in,
    input  logic [9:0]                                             vcount_in,
    input  logic                                                   new_frame_in,
    input  logic                                                   cfg_we_in,
    input  logic [(NUM_SPRITES > 1 ? $clog2(NUM_SPRITES) : 1)-1:0] cfg_idx_in,
    input  logic [10:0]                                            cfg_x_in,
    input  logic [9:0]                                             cfg_y_in,
    input  logic [(NUM_IMGS > 1 ? $clog2(NUM_IMGS) : 1)-1:0]       cfg_shape_in,
    input  logic                                                   cfg_en_in,
    input  logic                                                   cfg_flip_in,
    output logic                                                   draw_out,
    output logic [(NUM_SPRITES > 1 ? $clog2(NUM_SPRITES) : 1)-1:0] sprite_id_out,
    output logic                                                   collision_out,
    output logic [NUM_SPRITES-1:0]                                 collision_frame_out
);

    localparam int IDX_W = NUM_SPRITES > 1 ? $clog2(NUM_SPRITES) : 1;
    localparam int SHP_W = NUM_IMGS > 1 ? $clog2(NUM_IMGS) : 1;

    logic [NUM_SPRITES-1:0] contrib;

    for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_ch
        sprite_channel #(
            .WIDTH     (WIDTH),
            .HEIGHT    (HEIGHT),
            .NUM_IMGS  (NUM_IMGS),
            .SHP_W     (SHP_W),
            .INIT_FILE (INIT_FILE)
        ) u_ch (
            .pixel_clk_in (pixel_clk_in),
            .rst_n_in     (rst_n_in),
            .hcount_in    (hcount_in),
            .vcount_in    (vcount_in),
            .new_frame_in (new_frame_in),
            .cfg_we_in    (cfg_we_in && (cfg_idx_in == IDX_W'(i))),
            .cfg_x_in     (cfg_x_in),
            .cfg_y_in     (cfg_y_in),
            .cfg_shape_in (cfg_shape_in),
            .cfg_en_in    (cfg_en_in),
            .cfg_flip_in  (cfg_flip_in),
            .contrib_out  (contrib[i])
        );
    end

    logic [IDX_W-1:0] win_id;
    logic             multi;

    always_comb begin
        win_id = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (contrib[i]) win_id = IDX_W'(i);
        end
    end

    assign multi = (contrib & (contrib - NUM_SPRITES'(1))) != '0;

    logic [SPRITE_LATENCY-2:0] vld;
    logic                      vld_s3;
    logic [NUM_SPRITES-1:0]    coll_hits;
    logic [NUM_SPRITES-1:0]    coll_acc;

    assign vld_s3    = vld[SPRITE_LATENCY-2];
    assign coll_hits = (vld_s3 && multi) ? contrib : '0;

    // Hits on the commit cycle seed the new frame's accumulator rather than the reported one.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vld                 <= '0;
            draw_out            <= 1'b0;
            sprite_id_out       <= '0;
            collision_out       <= 1'b0;
            coll_acc            <= '0;
            collision_frame_out <= '0;
        end else begin
            vld           <= {vld[SPRITE_LATENCY-3:0], 1'b1};
            draw_out      <= vld_s3 && (contrib != '0);
            sprite_id_out <= vld_s3 ? win_id : '0;
            collision_out <= vld_s3 && multi;
            if (new_frame_in) begin
                collision_frame_out <= coll_acc;
                coll_acc            <= coll_hits;
            end else begin
                coll_acc <= coll_acc | coll_hits;
            end
        end
    end

endmodule

// File: tb/tb_sprite_layer_mask.sv
// Directed bench for sprite_layer_mask; mask shapes: 0 solid, 1 checker (row^col even), 2 left half.
module tb_sprite_layer_mask;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        new_frame = 1'b0;
    logic        cfg_we = 1'b0;
    logic [1:0]  cfg_idx = '0;
    logic [10:0] cfg_x = '0;
    logic [9:0]  cfg_y = '0;
    logic [1:0]  cfg_shape = '0;
    logic        cfg_en = 1'b0;
    logic        cfg_flip = 1'b0;
    logic        draw;
    logic [1:0]  sprite_id;
    logic        collision;
    logic [3:0]  collision_frame;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sprite_layer_mask #(
        .WIDTH       (128),
        .HEIGHT      (128),
        .NUM_IMGS    (3),
        .NUM_SPRITES (4),
        .INIT_FILE   ("all_shape_small_img_mask.mem")
    ) dut (
        .pixel_clk_in        (clk),
        .rst_n_in            (rst_n),
        .hcount_in           (hcount),
        .vcount_in           (vcount),
        .new_frame_in        (new_frame),
        .cfg_we_in           (cfg_we),
        .cfg_idx_in          (cfg_idx),
        .cfg_x_in            (cfg_x),
        .cfg_y_in            (cfg_y),
        .cfg_shape_in        (cfg_shape),
        .cfg_en_in           (cfg_en),
        .cfg_flip_in         (cfg_flip),
        .draw_out            (draw),
        .sprite_id_out       (sprite_id),
        .collision_out       (collision),
        .collision_frame_out (collision_frame)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cfg_write(input int idx, input int x, input int y, input int shape,
                             input bit en, input bit flip, input bit commit);
        @(negedge clk);
        cfg_we    = 1'b1;
        cfg_idx   = 2'(idx);
        cfg_x     = 11'(x);
        cfg_y     = 10'(y);
        cfg_shape = 2'(shape);
        cfg_en    = en;
        cfg_flip  = flip;
        new_frame = commit;
        @(negedge clk);
        cfg_we    = 1'b0;
        new_frame = 1'b0;
    endtask

    task automatic frame();
        @(negedge clk);
        new_frame = 1'b1;
        @(negedge clk);
        new_frame = 1'b0;
    endtask

    task automatic probe(input string tag, input int h, input int v,
                         input bit exp_draw, input int exp_id, input bit exp_coll);
        @(negedge clk);
        hcount = 11'(h);
        vcount = 10'(v);
        repeat (4) @(posedge clk);
        #1;
        check_val({tag, ".draw"}, 32'(draw), 32'(exp_draw));
        check_val({tag, ".id"}, 32'(sprite_id), 32'(exp_id));
        check_val({tag, ".coll"}, 32'(collision), 32'(exp_coll));
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_val("rst.draw", 32'(draw), 0);
        check_val("rst.id", 32'(sprite_id), 0);
        check_val("rst.coll", 32'(collision), 0);
        check_val("rst.cframe", 32'(collision_frame), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sprite 0 at (100,50), checker shape.
        cfg_write(0, 100, 50, 1, 1'b1, 1'b0, 1'b0);
        frame();
        @(negedge clk);
        hcount = 11'd99;
        vcount = 10'd50;
        repeat (5) @(negedge clk);
        hcount = 11'd100;
        @(negedge clk);
        hcount = 11'd99;
        repeat (2) @(posedge clk);
        #1 check_val("lat3.draw", 32'(draw), 0);
        @(posedge clk);
        #1 check_val("lat4.draw", 32'(draw), 1);
        @(posedge clk);
        #1 check_val("lat5.draw", 32'(draw), 0);

        probe("left_edge", 99, 50, 1'b0, 0, 1'b0);
        probe("right_out", 228, 50, 1'b0, 0, 1'b0);
        probe("col1", 101, 50, 1'b0, 0, 1'b0);
        probe("col127", 227, 50, 1'b0, 0, 1'b0);
        probe("col127r1", 227, 51, 1'b1, 0, 1'b0);
        probe("mid", 150, 100, 1'b1, 0, 1'b0);
        probe("bottom_out", 101, 178, 1'b0, 0, 1'b0);
        probe("bottom_row", 101, 177, 1'b1, 0, 1'b0);

        // Mirrored: column 0 lands at x+127.
        cfg_write(0, 100, 50, 1, 1'b1, 1'b1, 1'b0);
        frame();
        probe("flip_c0", 227, 50, 1'b1, 0, 1'b0);
        probe("flip_c127", 100, 50, 1'b0, 0, 1'b0);
        probe("flip_c126", 101, 50, 1'b1, 0, 1'b0);
        probe("flip_c125", 102, 50, 1'b0, 0, 1'b0);

        // Write coinciding with commit takes effect one frame later.
        cfg_write(0, 10, 50, 1, 1'b1, 1'b0, 1'b0);
        frame();
        cfg_write(0, 300, 50, 1, 1'b1, 1'b0, 1'b1);
        probe("race_old", 10, 50, 1'b1, 0, 1'b0);
        probe("race_new_early", 300, 50, 1'b0, 0, 1'b0);
        frame();
        probe("race_new", 300, 50, 1'b1, 0, 1'b0);
        probe("race_old_gone", 10, 50, 1'b0, 0, 1'b0);

        // Off the right edge: no wrap into low columns.
        cfg_write(0, 2000, 50, 1, 1'b1, 1'b0, 1'b0);
        frame();
        probe("wrap_h0", 0, 50, 1'b0, 0, 1'b0);
        probe("wrap_h4", 4, 50, 1'b0, 0, 1'b0);

        // Shape index beyond the image set disables the channel.
        cfg_write(0, 100, 50, 3, 1'b1, 1'b0, 1'b0);
        frame();
        probe("bad_shape", 100, 50, 1'b0, 0, 1'b0);
        probe("bad_shape2", 101, 51, 1'b0, 0, 1'b0);

        // Overlap of sprites 0 and 2, solid shapes.
        cfg_write(0, 150, 150, 0, 1'b1, 1'b0, 1'b0);
        cfg_write(2, 180, 190, 0, 1'b1, 1'b0, 1'b0);
        frame();
        check_val("cframe_clean", 32'(collision_frame), 0);
        probe("overlap", 200, 200, 1'b1, 0, 1'b1);
        probe("only_s2", 290, 300, 1'b1, 2, 1'b0);
        probe("only_s0", 160, 160, 1'b1, 0, 1'b0);
        frame();
        check_val("cframe", 32'(collision_frame), 32'h5);

        // Asynchronous reset mid-frame while drawing.
        probe("pre_rst", 200, 200, 1'b1, 0, 1'b1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst.draw", 32'(draw), 0);
        check_val("arst.id", 32'(sprite_id), 0);
        check_val("arst.coll", 32'(collision), 0);
        check_val("arst.cframe", 32'(collision_frame), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1 check_val("post_rst.draw", 32'(draw), 0);
        frame();
        repeat (6) @(posedge clk);
        #1 check_val("post_rst_frame.draw", 32'(draw), 0);
        cfg_write(1, 200, 200, 0, 1'b1, 1'b0, 1'b0);
        frame();
        probe("post_rst_cfg", 200, 200, 1'b1, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_layer_mask.md
# sprite_layer_mask

Multi-channel, frame-synchronised sprite mask renderer for the video pipeline. It draws up to NUM_SPRITES independently placed, optionally horizontally mirrored 1-bit shape masks from a shared shape set, and resolves overlaps by fixed priority. It also reports per-frame sprite collisions. It sits between the hcount/vcount generator and the pixel compositor, and replaces single-sprite mask lookups.

## Interface
Parameters:
- WIDTH, 128, sprite width in pixels (power of two)
- HEIGHT, 128, sprite height in pixels
- NUM_IMGS, 4, shapes in the mask ROM image
- NUM_SPRITES, 4, independent sprite channels (1..8)
- INIT_FILE, "all_shape_small_img_mask.mem", 1-bit mask image, shape-major then row-major

Ports:
- pixel_clk_in  in  1  pixel clock; the only clock
- rst_n_in  in  1  asynchronous, active-low reset
- hcount_in  in  11  current pixel column
- vcount_in  in  10  current pixel row
- new_frame_in  in  1  one-cycle pulse at frame start; commits shadow config
- cfg_we_in  in  1  shadow config write strobe
- cfg_idx_in  in  $clog2(NUM_SPRITES)  channel to write
- cfg_x_in  in  11  sprite left edge
- cfg_y_in  in  10  sprite top edge
- cfg_shape_in  in  $clog2(NUM_IMGS)  shape select
- cfg_en_in  in  1  channel enable
- cfg_flip_in  in  1  horizontal mirror
- draw_out  out  1  mask pixel set for the winning sprite
- sprite_id_out  out  $clog2(NUM_SPRITES)  index of the winning sprite; 0 when draw_out=0
- collision_out  out  1  two or more sprites drawn at this pixel
- collision_frame_out  out  NUM_SPRITES  sprites that collided during the previous frame

## Operation
- Each channel has a shadow register set and an active register set: x, y, shape, en, flip.
  - cfg_we_in writes the shadow set only.
  - new_frame_in copies shadow to active for all channels in the same cycle.
  - If cfg_we_in and new_frame_in occur in the same cycle, the commit copies the pre-write shadow value. The write lands in shadow and takes effect next frame.
- A channel is in range when x ≤ h < x+WIDTH and y ≤ v < y+HEIGHT.
  - Compare with 12-/11-bit sums; no wrap-around.
  - A sprite partly off-screen is clipped, never wrapped.
- Column: dx = h−x, or WIDTH−1−dx when flip=1.
- Address: shape·WIDTH·HEIGHT + dy·WIDTH + col, width $clog2(WIDTH·HEIGHT·NUM_IMGS).
- A channel contributes when en=1, shape<NUM_IMGS, in range, and mask bit=1. shape≥NUM_IMGS means the channel is disabled.
- When a channel is out of range, its address is forced to 0 and its in-range flag to 0.
- Priority: the lowest contributing index wins. draw_out is the OR of all contributions.
- collision_out = 1 when at least two channels contribute.
- A sticky collision accumulator sets bit i when channel i contributes while collision_out is asserted.
  - On new_frame_in, collision_frame_out takes the accumulator value and the accumulator clears.
  - A collision on the pulse cycle counts toward the new frame.
- Reset (asynchronous, any time, including mid-frame):
  - all shadow/active registers → 0, so every channel is disabled;
  - pipeline valid bits → 0;
  - draw_out=0, sprite_id_out=0, collision_out=0, collision_frame_out=0.
  - ROM contents are unaffected.

## Timing
- Fixed latency of 4 cycles from hcount_in/vcount_in to draw_out/sprite_id_out/collision_out.
  - S1: register range flags, address, and delayed counts.
  - S2–S3: ROM read (two-cycle, output-registered).
  - S4: priority resolve and output register.
- The range flag and the active config it was computed from travel with the pixel. A new_frame_in commit mid-pipeline does not alter pixels already in flight.
- First valid output after reset release: 4 cycles after the first sampled count.
- cfg writes are single-cycle with no backpressure; every write is accepted.

## Structure
- Package sprite_pkg:
  - sprite_cfg_t packed struct {x, y, shape, en, flip};
  - localparam SPRITE_LATENCY = 4;
  - address-width function.
- Sub-module sprite_channel, one instance per channel:
  - holds shadow/active regs, S1 range/address logic, ROM instance (xilinx_single_port_ram_read_first, HIGH_PERFORMANCE, rsta tied to ~rst_n_in) and flag delay;
  - outputs a 1-bit contribution at S3.
- Top level: generate loop, priority encoder, collision logic, and output registers.

## Test plan
- Sprite 0 at (100,50), shape 1, committed: compare against a model scan of the mask file. Pixel (100,50) appears on draw_out exactly 4 cycles later; pixels (99,50) and (228,50) give draw_out=0.
- flip=1 on sprite 0: the mask bit at column 0 appears at h=x+WIDTH−1; all other columns mirror.
- Sprites 0 and 2 overlap at (200,200) with both masks set: sprite_id_out=0 and collision_out=1. After the next new_frame_in, collision_frame_out=4'b0101.
- cfg_we_in changes x from 10 to 300 on the same cycle as new_frame_in: the current frame draws at x=10, and the following frame draws at x=300.
- x=2000 (partly off 11-bit range) or shape=NUM_IMGS: no wrap and no draw; draw_out stays 0.
- Assert rst_n_in mid-frame with draw_out=1: all outputs go to 0 immediately. After release, nothing draws until a config write is committed.
